bram_port_scheduler: RTL and testbench
======================================

BRAM_PORT_SCHEDULER -- requirements
Module: bram_port_scheduler

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, number of RAM words.
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), address width.
REQ-004 SHALL have parameter READ_LAT, default 1, cycles from BRAM port enable to data_out valid; legal range 1..4.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rst input 1.
REQ-006 SHALL have, for each requester n in {0,1}: reqn_valid input 1, reqn_ready output 1, reqn_we input 1, reqn_addr input ADDR_W, reqn_wdata input DWIDTH.
REQ-007 SHALL have, for each n: rspn_valid output 1 and rspn_rdata output DWIDTH (read response, no backpressure).
REQ-008 SHALL have BRAM-side outputs clk_en, port_en_0/1, wr_en_0/1, addr_in_0/1 (ADDR_W), data_in_0/1 (DWIDTH), and inputs data_out_0/1 (DWIDTH).
REQ-009 SHALL have conflict_cnt output 16, count of write-write same-address conflicts.

Function
REQ-010 SHALL hold one request slot per port (valid, we, addr, wdata); a request is accepted when reqn_valid and reqn_ready are both high on a rising clk edge.
REQ-011 SHALL drive reqn_ready = !slotn_valid || slotn issues this cycle (combinational).
REQ-012 SHALL issue a valid slot to its BRAM port unless it loses a conflict; issue drives port_en_n=1, wr_en_n=we, addr_in_n, data_in_n from the slot.
REQ-013 SHALL define conflict as both slots valid, both writes, equal addresses.
REQ-014 SHALL resolve a conflict with a one-bit round-robin pointer rr: port rr issues, the other port holds its slot and issues the next cycle; rr toggles on every conflict.
REQ-015 SHALL issue both ports in the same cycle for read/read, read/write or write/write to different addresses (BRAM resolves read/write same-address).
REQ-016 SHALL drive clk_en=1 whenever rst is low, and port_en_n=0, wr_en_n=0 when slot n does not issue.
REQ-017 SHALL assert rspn_valid exactly READ_LAT cycles after a read issue on port n, for one cycle, with rspn_rdata = data_out_n sampled in that cycle (extra READ_LAT-1 stages registered internally).
REQ-018 SHALL keep rspn_valid=0 for issued writes; rspn_rdata holds its last value when rspn_valid=0.
REQ-019 SHALL sustain one accepted request per port per cycle with no conflicts; latency accept->issue is 1 cycle.
REQ-020 SHALL increment conflict_cnt once per conflict cycle, saturating at 16'hFFFF.

Reset
REQ-021 SHALL on rst clear both slots, rr=0 (port 0 wins first conflict), all response pipeline stages, rspn_valid=0, rspn_rdata=0, conflict_cnt=0, port_en/wr_en=0, clk_en=0.
REQ-022 SHALL drop in-flight reads on rst assertion mid-operation; no rspn_valid is produced for them after reset release.
REQ-023 SHALL drive reqn_ready=1 in the first cycle after reset release.

Configuration
REQ-024 SHALL compile the conflict counter only when macro BRAM_SCHED_STATS_EN is defined; without it conflict_cnt SHALL be constant 0 and no counter register exists; arbitration is identical either way.

Structure
REQ-025 SHALL place the request-slot struct typedef, READ_LAT bounds and counter width constant in shared package bram_sched_pkg.
REQ-026 SHALL implement the per-port read-response delay line as sub-module bram_rsp_pipe, instantiated twice.

Verification
REQ-027 Reset then req0 write addr 0x10 data 0xA5, next cycle req0 read 0x10 -> rsp0_valid 2 cycles after read accept (READ_LAT=1), rsp0_rdata=0xA5.
REQ-028 Both ports write addr 0x20 same cycle (0x11, 0x22) -> port 0 issues first, req1_ready low one cycle, final RAM[0x20]=0x22, conflict_cnt=1, rr=1.
REQ-029 Second conflict at addr 0x20 (0x33, 0x44) -> port 1 issues first, final RAM[0x20]=0x33, conflict_cnt=2.
REQ-030 Continuous reads on both ports to 0x00..0xFF, 256 cycles -> 256 responses per port, in order, no ready deassertion.
REQ-031 Assert rst with two reads in flight (READ_LAT=3) -> no rspn_valid after release, all outputs at reset values.
REQ-032 Without BRAM_SCHED_STATS_EN, repeat REQ-028 -> identical data and ordering, conflict_cnt=0.

Source files
------------

// File: rtl/bram_sched_pkg.sv
// rtl/bram_sched_pkg.sv - shared types and constants for bram_port_scheduler
package bram_sched_pkg;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 4;
    localparam int CNT_W        = 16;

    // Slot fields are sized for the widest supported configuration; the top truncates on use.
    localparam int SLOT_ADDR_W  = 16;
    localparam int SLOT_DATA_W  = 64;

    typedef struct packed {
        logic                   valid;
        logic                   we;
        logic [SLOT_ADDR_W-1:0] addr;
        logic [SLOT_DATA_W-1:0] wdata;
    } slot_t;

    function automatic slot_t new_slot(input logic we,
                                       input logic [SLOT_ADDR_W-1:0] addr,
                                       input logic [SLOT_DATA_W-1:0] wdata);
        slot_t s;
        s.valid = 1'b1;
        s.we    = we;
        s.addr  = addr;
        s.wdata = wdata;
        return s;
    endfunction

endpackage

// File: rtl/bram_port_scheduler_if.sv
// rtl/bram_port_scheduler_if.sv - requester-side request/response bundle for both ports
interface bram_port_scheduler_if #(
    parameter int DWIDTH = 8,
    parameter int ADDR_W = 8
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DWIDTH-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DWIDTH-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DWIDTH-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DWIDTH-1:0] rsp1_rdata;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata
    );
endinterface

// File: rtl/bram_rsp_pipe.sv
// rtl/bram_rsp_pipe.sv - per-port read-response delay line matching BRAM read latency
module bram_rsp_pipe #(
    parameter int DWIDTH   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_rd,
    input  logic [DWIDTH-1:0] data_out,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata
);
    logic [READ_LAT-1:0] stage;
    logic [DWIDTH-1:0]   hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
            hold  <= '0;
        end else begin
            stage[0] <= issue_rd;
            for (int i = 1; i < READ_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
            if (rsp_valid) begin
                hold <= data_out;
            end
        end
    end

    // Data is taken straight from the BRAM in the response cycle and held afterwards.
    assign rsp_valid = stage[READ_LAT-1];
    assign rsp_rdata = rsp_valid ? data_out : hold;

endmodule

// File: rtl/bram_port_scheduler.sv
// rtl/bram_port_scheduler.sv - two-requester scheduler for a dual-port BRAM; conflict counter under BRAM_SCHED_STATS_EN
module bram_port_scheduler
    import bram_sched_pkg::*;
#(
    parameter int DWIDTH   = 8,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    bram_port_scheduler_if.slave ifc,
    output logic                clk_en,
    output logic                port_en_0,
    output logic                port_en_1,
    output logic                wr_en_0,
    output logic                wr_en_1,
    output logic [ADDR_W-1:0]   addr_in_0,
    output logic [ADDR_W-1:0]   addr_in_1,
    output logic [DWIDTH-1:0]   data_in_0,
    output logic [DWIDTH-1:0]   data_in_1,
    input  logic [DWIDTH-1:0]   data_out_0,
    input  logic [DWIDTH-1:0]   data_out_1,
    output logic [CNT_W-1:0]    conflict_cnt
);
    localparam int LAT = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                         (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;

    slot_t slot0, slot1;
    logic  rr;
    logic  conflict, issue0, issue1, ready0, ready1;
    logic  rsp0_valid, rsp1_valid;
    logic [DWIDTH-1:0] rsp0_rdata, rsp1_rdata;

    always_comb begin
        conflict  = 1'b0;
        issue0    = 1'b0;
        issue1    = 1'b0;
        conflict  = slot0.valid && slot1.valid && slot0.we && slot1.we &&
                    (slot0.addr == slot1.addr);
        // The rr-selected port wins a conflict; the loser keeps its slot for next cycle.
        issue0    = slot0.valid && !(conflict && rr);
        issue1    = slot1.valid && !(conflict && !rr);
        ready0    = !slot0.valid || issue0;
        ready1    = !slot1.valid || issue1;
        port_en_0 = issue0;
        port_en_1 = issue1;
        wr_en_0   = issue0 && slot0.we;
        wr_en_1   = issue1 && slot1.we;
        addr_in_0 = slot0.addr[ADDR_W-1:0];
        addr_in_1 = slot1.addr[ADDR_W-1:0];
        data_in_0 = slot0.wdata[DWIDTH-1:0];
        data_in_1 = slot1.wdata[DWIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            rr    <= 1'b0;
        end else begin
            if (ifc.req0_valid && ready0) begin
                slot0 <= new_slot(ifc.req0_we, SLOT_ADDR_W'(ifc.req0_addr),
                                  SLOT_DATA_W'(ifc.req0_wdata));
            end else if (issue0) begin
                slot0.valid <= 1'b0;
            end
            if (ifc.req1_valid && ready1) begin
                slot1 <= new_slot(ifc.req1_we, SLOT_ADDR_W'(ifc.req1_addr),
                                  SLOT_DATA_W'(ifc.req1_wdata));
            end else if (issue1) begin
                slot1.valid <= 1'b0;
            end
            if (conflict) begin
                rr <= ~rr;
            end
        end
    end

    // Upper slot bits beyond the configured widths are intentionally left unconsumed.
    logic unused_slot_bits;
    assign unused_slot_bits = ^{slot0, slot1};

    assign clk_en         = ~rst;
    assign ifc.req0_ready = ready0;
    assign ifc.req1_ready = ready1;
    assign ifc.rsp0_valid = rsp0_valid;
    assign ifc.rsp1_valid = rsp1_valid;
    assign ifc.rsp0_rdata = rsp0_rdata;
    assign ifc.rsp1_rdata = rsp1_rdata;

    bram_rsp_pipe #(.DWIDTH(DWIDTH), .READ_LAT(LAT)) u_rsp_pipe_0 (
        .clk       (clk),
        .rst       (rst),
        .issue_rd  (issue0 && !slot0.we),
        .data_out  (data_out_0),
        .rsp_valid (rsp0_valid),
        .rsp_rdata (rsp0_rdata)
    );

    bram_rsp_pipe #(.DWIDTH(DWIDTH), .READ_LAT(LAT)) u_rsp_pipe_1 (
        .clk       (clk),
        .rst       (rst),
        .issue_rd  (issue1 && !slot1.we),
        .data_out  (data_out_1),
        .rsp_valid (rsp1_valid),
        .rsp_rdata (rsp1_rdata)
    );

`ifdef BRAM_SCHED_STATS_EN
    logic [CNT_W-1:0] conflict_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= '0;
        end else if (conflict && (conflict_q != {CNT_W{1'b1}})) begin
            conflict_q <= conflict_q + CNT_W'(1);
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_bram_port_scheduler.sv
// tb/tb_bram_port_scheduler.sv - directed self-checking bench for bram_port_scheduler
module tb_bram_port_scheduler;

`ifdef BRAM_SCHED_STATS_EN
    localparam int EXP_C1 = 1;
    localparam int EXP_C2 = 2;
`else
    localparam int EXP_C1 = 0;
    localparam int EXP_C2 = 0;
`endif

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    bram_port_scheduler_if #(.DWIDTH(8), .ADDR_W(8)) ifa ();
    bram_port_scheduler_if #(.DWIDTH(8), .ADDR_W(8)) ifb ();

    logic       ce_a, pe_a0, pe_a1, we_a0, we_a1;
    logic [7:0] addr_a0, addr_a1, din_a0, din_a1, qa0, qa1;
    logic [15:0] cnt_a;
    logic       ce_b, pe_b0, pe_b1, we_b0, we_b1;
    logic [7:0] addr_b0, addr_b1, din_b0, din_b1;
    logic [15:0] cnt_b;
    logic [7:0] qb0 [0:2];
    logic [7:0] qb1 [0:2];
    logic [7:0] mem [0:255];

    bram_port_scheduler #(.DWIDTH(8), .DEPTH(256), .ADDR_W(8), .READ_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .ifc(ifa), .clk_en(ce_a),
        .port_en_0(pe_a0), .port_en_1(pe_a1), .wr_en_0(we_a0), .wr_en_1(we_a1),
        .addr_in_0(addr_a0), .addr_in_1(addr_a1), .data_in_0(din_a0), .data_in_1(din_a1),
        .data_out_0(qa0), .data_out_1(qa1), .conflict_cnt(cnt_a)
    );

    bram_port_scheduler #(.DWIDTH(8), .DEPTH(256), .ADDR_W(8), .READ_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .ifc(ifb), .clk_en(ce_b),
        .port_en_0(pe_b0), .port_en_1(pe_b1), .wr_en_0(we_b0), .wr_en_1(we_b1),
        .addr_in_0(addr_b0), .addr_in_1(addr_b1), .data_in_0(din_b0), .data_in_1(din_b1),
        .data_out_0(qb0[2]), .data_out_1(qb1[2]), .conflict_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port RAM with one-cycle read latency behind dut_a.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hC3;
        end else begin
            if (pe_a0 && we_a0) mem[addr_a0] <= din_a0;
            if (pe_a1 && we_a1) mem[addr_a1] <= din_a1;
        end
        qa0 <= mem[addr_a0];
        qa1 <= mem[addr_a1];
    end

    // Three-cycle read path behind dut_b returning a fixed function of the address.
    always @(posedge clk) begin
        qb0[0] <= addr_b0 ^ 8'hC3;
        qb0[1] <= qb0[0];
        qb0[2] <= qb0[1];
        qb1[0] <= addr_b1 ^ 8'h3C;
        qb1[1] <= qb1[0];
        qb1[2] <= qb1[1];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_rd(input int a);
        if (a == 16) return 8'hA5;
        if (a == 32) return 8'h33;
        return 8'(a) ^ 8'hC3;
    endfunction

    initial begin
        int r0, r1, drops, stray;
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        ifa.req0_valid = 0; ifa.req0_we = 0; ifa.req0_addr = 0; ifa.req0_wdata = 0;
        ifa.req1_valid = 0; ifa.req1_we = 0; ifa.req1_addr = 0; ifa.req1_wdata = 0;
        ifb.req0_valid = 0; ifb.req0_we = 0; ifb.req0_addr = 0; ifb.req0_wdata = 0;
        ifb.req1_valid = 0; ifb.req1_we = 0; ifb.req1_addr = 0; ifb.req1_wdata = 0;
        step(); step(); step();
        chk("rst_clk_en", ce_a, 0);
        chk("rst_port_en_0", pe_a0, 0);
        chk("rst_wr_en_1", we_a1, 0);
        chk("rst_rsp0_valid", ifa.rsp0_valid, 0);
        chk("rst_rsp0_rdata", ifa.rsp0_rdata, 0);
        chk("rst_cnt", cnt_a, 0);
        rst = 1'b0;
        #1;
        chk("rel_clk_en", ce_a, 1);
        chk("rel_req0_ready", ifa.req0_ready, 1);
        chk("rel_req1_ready", ifa.req1_ready, 1);

        // Write 0x10 then read it back.
        ifa.req0_valid = 1; ifa.req0_we = 1; ifa.req0_addr = 8'h10; ifa.req0_wdata = 8'hA5;
        step();
        chk("wr_port_en_0", pe_a0, 1);
        chk("wr_wr_en_0", we_a0, 1);
        chk("wr_addr_in_0", addr_a0, 8'h10);
        chk("wr_data_in_0", din_a0, 8'hA5);
        chk("wr_req0_ready", ifa.req0_ready, 1);
        ifa.req0_we = 0;
        step();
        chk("rd_port_en_0", pe_a0, 1);
        chk("rd_wr_en_0", we_a0, 0);
        chk("wr_no_rsp", ifa.rsp0_valid, 0);
        ifa.req0_valid = 0;
        step();
        chk("rd_rsp0_valid", ifa.rsp0_valid, 1);
        chk("rd_rsp0_rdata", ifa.rsp0_rdata, 8'hA5);
        chk("idle_port_en_0", pe_a0, 0);
        step();
        chk("rd_rsp0_pulse", ifa.rsp0_valid, 0);
        chk("rd_rsp0_hold", ifa.rsp0_rdata, 8'hA5);

        // First conflict: port 0 wins.
        ifa.req0_valid = 1; ifa.req0_we = 1; ifa.req0_addr = 8'h20; ifa.req0_wdata = 8'h11;
        ifa.req1_valid = 1; ifa.req1_we = 1; ifa.req1_addr = 8'h20; ifa.req1_wdata = 8'h22;
        step();
        chk("c1_port_en_0", pe_a0, 1);
        chk("c1_port_en_1", pe_a1, 0);
        chk("c1_req1_ready", ifa.req1_ready, 0);
        chk("c1_req0_ready", ifa.req0_ready, 1);
        chk("c1_data_in_0", din_a0, 8'h11);
        ifa.req0_valid = 0; ifa.req1_valid = 0;
        step();
        chk("c1b_port_en_1", pe_a1, 1);
        chk("c1b_wr_en_1", we_a1, 1);
        chk("c1b_data_in_1", din_a1, 8'h22);
        chk("c1b_port_en_0", pe_a0, 0);
        chk("c1b_req1_ready", ifa.req1_ready, 1);
        step();
        chk("c1_ram", mem[8'h20], 8'h22);
        chk("c1_cnt", cnt_a, EXP_C1);

        // Second conflict: port 1 wins.
        ifa.req0_valid = 1; ifa.req0_wdata = 8'h33;
        ifa.req1_valid = 1; ifa.req1_wdata = 8'h44;
        step();
        chk("c2_port_en_1", pe_a1, 1);
        chk("c2_port_en_0", pe_a0, 0);
        chk("c2_req0_ready", ifa.req0_ready, 0);
        chk("c2_data_in_1", din_a1, 8'h44);
        ifa.req0_valid = 0; ifa.req1_valid = 0;
        step();
        chk("c2b_port_en_0", pe_a0, 1);
        chk("c2b_data_in_0", din_a0, 8'h33);
        step();
        chk("c2_ram", mem[8'h20], 8'h33);
        chk("c2_cnt", cnt_a, EXP_C2);

        // Back-to-back reads on both ports over the whole address space.
        r0 = 0; r1 = 0; drops = 0;
        ifa.req0_we = 0; ifa.req1_we = 0;
        for (int i = 0; i < 259; i++) begin
            if (i < 256) begin
                ifa.req0_valid = 1; ifa.req1_valid = 1;
                ifa.req0_addr = 8'(i); ifa.req1_addr = 8'(i);
                if (!(ifa.req0_ready && ifa.req1_ready)) drops++;
            end else begin
                ifa.req0_valid = 0; ifa.req1_valid = 0;
            end
            step();
            if (ifa.rsp0_valid) begin
                chk("stream_rsp0", ifa.rsp0_rdata, exp_rd(r0));
                r0++;
            end
            if (ifa.rsp1_valid) begin
                chk("stream_rsp1", ifa.rsp1_rdata, exp_rd(r1));
                r1++;
            end
        end
        chk("stream_cnt0", r0, 256);
        chk("stream_cnt1", r1, 256);
        chk("stream_ready_drops", drops, 0);

        // READ_LAT=3 instance: one clean read, then reset with two reads in flight.
        ifb.req0_valid = 1; ifb.req0_addr = 8'h05;
        step();
        ifb.req0_valid = 0;
        chk("l3_issue", pe_b0, 1);
        step();
        step();
        chk("l3_not_yet", ifb.rsp0_valid, 0);
        step();
        chk("l3_rsp_valid", ifb.rsp0_valid, 1);
        chk("l3_rsp_rdata", ifb.rsp0_rdata, 8'hC6);
        ifb.req0_valid = 1; ifb.req0_addr = 8'h07;
        ifb.req1_valid = 1; ifb.req1_addr = 8'h08;
        step();
        ifb.req0_valid = 0; ifb.req1_valid = 0;
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_port_en_0", pe_b0, 0);
        chk("mid_rst_clk_en", ce_b, 0);
        chk("mid_rst_rsp0_rdata", ifb.rsp0_rdata, 0);
        chk("mid_rst_cnt", cnt_b, 0);
        step(); step();
        rst = 1'b0;
        #1;
        chk("post_rst_req0_ready", ifb.req0_ready, 1);
        chk("post_rst_req1_ready", ifb.req1_ready, 1);
        chk("post_rst_clk_en", ce_b, 1);
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            if (ifb.rsp0_valid || ifb.rsp1_valid) stray++;
            step();
        end
        chk("post_rst_no_rsp", stray, 0);
        chk("post_rst_rsp1_rdata", ifb.rsp1_rdata, 0);
        chk("post_rst_port_en_1", pe_b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
